regfile_arbiter: RTL and testbench
==================================

# regfile_arbiter

Two-requester arbiter and sequencer in front of the single-port `RegFile` (WIDTH 16, DEPTH 8, ADDR 3).
- Accepts read/write commands from two independent requesters over a req/grant handshake.
- Grants them round-robin and drives the `RegFile` `WrEn`/`RdEn`/`Address`/`WrData` pins, one transaction at a time.
- Returns read data to the owning requester with a one-cycle valid pulse.

## Interface
Parameters:
- `WIDTH`, 16, data width; must match `RegFile` `WIDTH`.
- `ADDR`, 3, address width; must match `RegFile` `ADDR`.

Ports:
- `CLK`  in  1  single clock; all logic on the rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `Req0` / `Req1`  in  1  request from requester 0 / 1; held high until the matching grant is seen.
- `Wr0` / `Wr1`  in  1  command type: 1 = write, 0 = read. Valid while `ReqN` is high.
- `Addr0` / `Addr1`  in  `ADDR`  target register.
- `WData0` / `WData1`  in  `WIDTH`  write data; ignored for reads.
- `Gnt0` / `Gnt1`  out  1  one-cycle pulse; the command was accepted and latched.
- `RValid0` / `RValid1`  out  1  one-cycle pulse; `RDataN` holds read data.
- `RData0` / `RData1`  out  `WIDTH`  read data. Holds its value until the next read completes for that requester.
- `RF_WrEn`  out  1  to `RegFile` `WrEn`.
- `RF_RdEn`  out  1  to `RegFile` `RdEn`.
- `RF_Address`  out  `ADDR`  to `RegFile` `Address`.
- `RF_WrData`  out  `WIDTH`  to `RegFile` `WrData`.
- `RF_RdData`  in  `WIDTH`  from `RegFile` `RdData`. The `RegFile` registers this output on the edge where `RdEn` is sampled.

## Operation
- All outputs are registered.
- States:
  - IDLE: no access in progress.
  - ACCESS: one `RegFile` access is driven.
  - CAPTURE: reads only; read data is collected.
- Priority pointer `last` holds the most recently granted requester.

IDLE:
- If exactly one `ReqN` is high, grant N.
- If both are high, grant the requester that is not `last`.
- On grant, at the same edge:
  - pulse `GntN`;
  - latch `AddrN` into `RF_Address`, `WDataN` into `RF_WrData`, and the owner ID;
  - set `RF_WrEn = WrN` and `RF_RdEn = ~WrN`;
  - set `last = N`;
  - go to ACCESS.
- With no request, stay in IDLE. Enables stay 0; `RF_Address` and `RF_WrData` hold their values.

ACCESS:
- Lasts exactly one cycle. The `RegFile` performs the write, or registers the read, at the exiting edge.
- At that edge, clear `RF_WrEn`, `RF_RdEn` and `GntN`.
- A write goes to IDLE; a read goes to CAPTURE.

CAPTURE:
- Lasts one cycle.
- At the exiting edge, load `RF_RdData` into the owner's `RDataN`, pulse the owner's `RValidN`, and go to IDLE.

General rules:
- Only one of `RF_WrEn` / `RF_RdEn` is ever high, and only in ACCESS.
- Requests are sampled only in IDLE. `ReqN` still high in the `GntN` cycle is not a new request.
- A requester that keeps `ReqN` high after its grant gets a new transaction on the next IDLE evaluation.
- With both requesters holding requests, grants alternate 0,1,0,1…

Reset (`RST` high, any time, including mid-transaction):
- State goes to IDLE and `last` = 1, so requester 0 wins the first tie.
- Every output is cleared to 0: grants, valids, `RDataN`, all `RF_*` outputs.
- An in-flight transaction is abandoned. No `GntN` or `RValidN` is produced for it.
- An abandoned write may or may not have reached the `RegFile`.

## Timing
- Write: request seen at edge E0, so `GntN` and `RF_WrEn` are high in cycle E0–E1. The `RegFile` is written at E1. The controller returns to IDLE at E1 and can grant again at E2. Throughput: one write per 2 cycles.
- Read: `GntN` and `RF_RdEn` are high in E0–E1. `RF_RdData` is valid in E1–E2. `RDataN` and `RValidN` update at E2. The next grant can come at E3. Throughput: one read per 3 cycles; latency from grant to `RValidN` is 2 cycles.
- Requester rules:
  - `ReqN`, `WrN`, `AddrN` and `WDataN` must be stable from assertion until the edge that raises `GntN`.
  - They are don't-care after that edge.
  - `ReqN` must drop before the following edge unless another transaction is wanted.

## Test plan
- Reset: drive `RST`=1 mid-stream → all outputs 0, state IDLE. Then `Req0`/`Req1` both high → `Gnt0` first.
- Single writes then reads: req0 writes 0x000E to addr 0 and 0x000D to addr 1; req1 writes 0x000B to addr 2 and 0x0007 to addr 3; then read addrs 0–3 → data back on the issuing requester's `RData` with `RValid` exactly 2 cycles after `Gnt`, values 0x000E, 0x000D, 0x000B, 0x0007.
- Contention: both requesters hold `Req` for 4 transactions each → grants strictly alternate 0,1,0,1…; `RF_WrEn` and `RF_RdEn` never high together.
- Routing: req0 reads addr 2 while req1 writes 0x1234 to addr 5 at the same edge → req0 gets `RValid0` with 0x000B. `RValid1` never pulses, and `RData1` is unchanged.
- Back-to-back: req0 keeps `Req0` high for write, read, write to addr 7 → grant spacing 2, 3 cycles. Read returns the first write's value.
- Reset during CAPTURE: `RST` pulse between `Gnt0` (read) and the expected `RValid0` → no `RValid0`, `RData0` = 0.

Source files
------------

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter and sequencer that lets two requesters share one single-port RegFile.
// Each command runs as one ACCESS cycle; reads add one CAPTURE cycle before data is returned.
module regfile_arbiter #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned ADDR  = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Req0,
    input  logic             Req1,
    input  logic             Wr0,
    input  logic             Wr1,
    input  logic [ADDR-1:0]  Addr0,
    input  logic [ADDR-1:0]  Addr1,
    input  logic [WIDTH-1:0] WData0,
    input  logic [WIDTH-1:0] WData1,
    output logic             Gnt0,
    output logic             Gnt1,
    output logic             RValid0,
    output logic             RValid1,
    output logic [WIDTH-1:0] RData0,
    output logic [WIDTH-1:0] RData1,
    output logic             RF_WrEn,
    output logic             RF_RdEn,
    output logic [ADDR-1:0]  RF_Address,
    output logic [WIDTH-1:0] RF_WrData,
    input  logic [WIDTH-1:0] RF_RdData
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StAccess  = 2'd1;
    localparam logic [1:0] StCapture = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             last_q, last_d;
    logic             owner_q, owner_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             rvalid0_q, rvalid0_d;
    logic             rvalid1_q, rvalid1_d;
    logic [WIDTH-1:0] rdata0_q, rdata0_d;
    logic [WIDTH-1:0] rdata1_q, rdata1_d;
    logic             wr_en_q, wr_en_d;
    logic             rd_en_q, rd_en_d;
    logic [ADDR-1:0]  addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;

    logic pick;
    logic pick_wr;

    // On a tie the requester that was not granted last wins.
    always_comb begin
        pick = Req1;
        if (Req0 && Req1) begin
            pick = ~last_q;
        end
        pick_wr = pick ? Wr1 : Wr0;
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        owner_d   = owner_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;

        case (state_q)
            StIdle: begin
                if (Req0 || Req1) begin
                    gnt0_d  = ~pick;
                    gnt1_d  = pick;
                    owner_d = pick;
                    last_d  = pick;
                    addr_d  = pick ? Addr1 : Addr0;
                    wdata_d = pick ? WData1 : WData0;
                    wr_en_d = pick_wr;
                    rd_en_d = ~pick_wr;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                state_d = wr_en_q ? StIdle : StCapture;
            end
            StCapture: begin
                // RegFile output was registered at the ACCESS exit edge.
                if (owner_q) begin
                    rdata1_d  = RF_RdData;
                    rvalid1_d = 1'b1;
                end else begin
                    rdata0_d  = RF_RdData;
                    rvalid0_d = 1'b1;
                end
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= StIdle;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign Gnt0       = gnt0_q;
    assign Gnt1       = gnt1_q;
    assign RValid0    = rvalid0_q;
    assign RValid1    = rvalid1_q;
    assign RData0     = rdata0_q;
    assign RData1     = rdata1_q;
    assign RF_WrEn    = wr_en_q;
    assign RF_RdEn    = rd_en_q;
    assign RF_Address = addr_q;
    assign RF_WrData  = wdata_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Scoreboard bench for regfile_arbiter with a behavioural single-port RegFile attached.
module tb_regfile_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        Req0 = 1'b0, Req1 = 1'b0, Wr0 = 1'b0, Wr1 = 1'b0;
    logic [2:0]  Addr0 = '0, Addr1 = '0;
    logic [15:0] WData0 = '0, WData1 = '0;
    logic        Gnt0, Gnt1, RValid0, RValid1;
    logic [15:0] RData0, RData1;
    logic        RF_WrEn, RF_RdEn;
    logic [2:0]  RF_Address;
    logic [15:0] RF_WrData;
    logic [15:0] RF_RdData;

    regfile_arbiter #(.WIDTH(16), .ADDR(3)) dut (
        .CLK(CLK), .RST(RST),
        .Req0(Req0), .Req1(Req1), .Wr0(Wr0), .Wr1(Wr1),
        .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
        .Gnt0(Gnt0), .Gnt1(Gnt1), .RValid0(RValid0), .RValid1(RValid1),
        .RData0(RData0), .RData1(RData1),
        .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address),
        .RF_WrData(RF_WrData), .RF_RdData(RF_RdData)
    );

    always #5 CLK = ~CLK;

    // Behavioural RegFile: write and registered read on the same edge the enables are sampled.
    logic [15:0] mem [8];
    initial begin
        for (int i = 0; i < 8; i++) mem[i] = '0;
        RF_RdData = '0;
    end
    always @(posedge CLK) begin
        if (RF_WrEn) mem[RF_Address] <= RF_WrData;
        if (RF_RdEn) RF_RdData <= mem[RF_Address];
    end

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    logic [15:0] exp0[$], exp1[$];
    int          rdg0[$], rdg1[$];
    int          gnt_log[$];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] out_bundle();
        return {7'd0, Gnt0, Gnt1, RValid0, RValid1, RData0, RData1,
                RF_WrEn, RF_RdEn, RF_Address, RF_WrData};
    endfunction

    // Output monitor: logs grants and checks every returned read against the scoreboard.
    always @(negedge CLK) begin
        if (!RST) begin
            check("rf_en_exclusive", {63'd0, RF_WrEn & RF_RdEn}, 64'd0);
            if (Gnt0 && Gnt1) check("gnt_exclusive", 64'd1, 64'd0);
            if (Gnt0) begin
                gnt_log.push_back(0);
                if (RF_RdEn) rdg0.push_back(cyc);
            end
            if (Gnt1) begin
                gnt_log.push_back(1);
                if (RF_RdEn) rdg1.push_back(cyc);
            end
            if (RValid0) begin
                if (exp0.size() == 0 || rdg0.size() == 0) check("rvalid0_unexpected", 64'd1, 64'd0);
                else begin
                    check("rdata0", RData0, exp0.pop_front());
                    check("latency0", cyc - rdg0.pop_front(), 64'd2);
                end
            end
            if (RValid1) begin
                if (exp1.size() == 0 || rdg1.size() == 0) check("rvalid1_unexpected", 64'd1, 64'd0);
                else begin
                    check("rdata1", RData1, exp1.pop_front());
                    check("latency1", cyc - rdg1.pop_front(), 64'd2);
                end
            end
        end
    end

    // Issue one command from requester n; called just after a rising edge.
    task automatic req_txn(input int n, input bit wr, input logic [2:0] a, input logic [15:0] d,
                           input bit keep, output int gcyc);
        bit seen = 1'b0;
        gcyc = -1;
        if (n == 0) begin
            Req0 = 1'b1; Wr0 = wr; Addr0 = a; WData0 = wr ? d : 16'hxxxx;
            if (!wr) exp0.push_back(d);
        end else begin
            Req1 = 1'b1; Wr1 = wr; Addr1 = a; WData1 = wr ? d : 16'hxxxx;
            if (!wr) exp1.push_back(d);
        end
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge CLK);
            #1;
            seen = (n == 0) ? Gnt0 : Gnt1;
        end
        if (!seen) check("gnt_timeout", 64'd0, 64'd1);
        gcyc = cyc;
        if (!keep) begin
            if (n == 0) Req0 = 1'b0;
            else Req1 = 1'b0;
        end
    endtask

    int g0, g1, g2;

    initial begin
        // Reset state
        repeat (2) @(negedge CLK);
        check("reset_outputs", out_bundle(), 64'd0);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // Writes from both requesters; first tie after reset goes to requester 0
        gnt_log.delete();
        fork
            begin
                req_txn(0, 1'b1, 3'd0, 16'h000E, 1'b0, g0);
                req_txn(0, 1'b1, 3'd1, 16'h000D, 1'b0, g0);
            end
            begin
                req_txn(1, 1'b1, 3'd2, 16'h000B, 1'b0, g1);
                req_txn(1, 1'b1, 3'd3, 16'h0007, 1'b0, g1);
            end
        join
        check("first_tie_gnt0", gnt_log[0], 64'd0);
        fork
            begin
                req_txn(0, 1'b0, 3'd0, 16'h000E, 1'b0, g0);
                req_txn(0, 1'b0, 3'd1, 16'h000D, 1'b0, g0);
            end
            begin
                req_txn(1, 1'b0, 3'd2, 16'h000B, 1'b0, g1);
                req_txn(1, 1'b0, 3'd3, 16'h0007, 1'b0, g1);
            end
        join
        repeat (4) @(posedge CLK);
        #1;

        // Contention: four transactions each, grants must alternate
        gnt_log.delete();
        fork
            begin
                req_txn(0, 1'b1, 3'd4, 16'hA0A0, 1'b0, g0);
                req_txn(0, 1'b0, 3'd4, 16'hA0A0, 1'b0, g0);
                req_txn(0, 1'b1, 3'd6, 16'h6060, 1'b0, g0);
                req_txn(0, 1'b0, 3'd6, 16'h6060, 1'b0, g0);
            end
            begin
                req_txn(1, 1'b1, 3'd5, 16'h5050, 1'b0, g1);
                req_txn(1, 1'b0, 3'd5, 16'h5050, 1'b0, g1);
                req_txn(1, 1'b1, 3'd7, 16'h7777, 1'b0, g1);
                req_txn(1, 1'b0, 3'd7, 16'h7777, 1'b0, g1);
            end
        join
        repeat (4) @(posedge CLK);
        #1;
        check("contention_count", gnt_log.size(), 64'd8);
        for (int i = 1; i < gnt_log.size(); i++) begin
            check("alternation", gnt_log[i], {63'd0, ~gnt_log[i-1][0]});
        end

        // Routing: req0 reads while req1 writes
        fork
            req_txn(0, 1'b0, 3'd2, 16'h000B, 1'b0, g0);
            req_txn(1, 1'b1, 3'd5, 16'h1234, 1'b0, g1);
        join
        repeat (5) @(posedge CLK);
        #1;
        check("rdata1_held", RData1, 64'h7777);
        check("rdata0_routed", RData0, 64'h000B);

        // Back-to-back from one requester holding Req0
        req_txn(0, 1'b1, 3'd7, 16'h00C3, 1'b1, g0);
        req_txn(0, 1'b0, 3'd7, 16'h00C3, 1'b1, g1);
        req_txn(0, 1'b1, 3'd7, 16'h003C, 1'b0, g2);
        check("b2b_wr_rd_spacing", g1 - g0, 64'd2);
        check("b2b_rd_wr_spacing", g2 - g1, 64'd3);
        repeat (3) @(posedge CLK);
        #1;

        // Reset while the read sits in CAPTURE
        req_txn(0, 1'b0, 3'd7, 16'h003C, 1'b0, g0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        #1;
        check("midrst_outputs", out_bundle(), 64'd0);
        exp0.delete();
        rdg0.delete();
        @(negedge CLK);
        RST = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        check("midrst_rdata0", RData0, 64'd0);

        // Tie after reset again favours requester 0
        gnt_log.delete();
        fork
            req_txn(1, 1'b1, 3'd1, 16'h1111, 1'b0, g1);
            req_txn(0, 1'b1, 3'd0, 16'h2222, 1'b0, g0);
        join
        check("post_rst_tie_gnt0", gnt_log[0], 64'd0);
        fork
            req_txn(0, 1'b0, 3'd0, 16'h2222, 1'b0, g0);
            req_txn(1, 1'b0, 3'd1, 16'h1111, 1'b0, g1);
        join
        repeat (6) @(posedge CLK);
        #1;
        check("exp0_drained", exp0.size(), 64'd0);
        check("exp1_drained", exp1.size(), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

endmodule
